// File: rtl/ubc_sequencer_if.sv
// ----------------------------------------------------------------------------
// ubc_sequencer_if
// Command channel between a host/control FSM and ubc_sequencer.
//
// Handshake: the host holds cmd_valid together with cmd_op/cmd_data/cmd_steps
// stable. A command transfers on the rising clk edge where cmd_valid and
// cmd_ready are both high. cmd_ready does not depend on cmd_valid. A
// cmd_valid seen while cmd_ready is low is not stored. The host may drop it,
// or keep presenting it until it transfers.
//
// Signals:
//   cmd_valid  host -> seq  command present
//   cmd_ready  seq  -> host sequencer can accept a command
//   cmd_op     host -> seq  00 LOAD, 01 UP, 10 DOWN, 11 BOUNCE
//   cmd_data   host -> seq  load value (LOAD only)
//   cmd_steps  host -> seq  step count (UP/DOWN/BOUNCE)
// ----------------------------------------------------------------------------
interface ubc_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int STEPW = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [STEPW-1:0] cmd_steps;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        output cmd_steps,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        input  cmd_steps,
        output cmd_ready
    );
endinterface

// File: rtl/ubc_sequencer.sv
// ----------------------------------------------------------------------------
// ubc_sequencer
// Command-driven controller for one loadable up/down counter (ubc). The
// sequencer takes one command at a time and runs it on the counter:
//   LOAD    load a value into the counter
//   UP N    count up N steps
//   DOWN N  count down N steps
//   BOUNCE  count up N steps, then down N steps
// It pulses done when a command completes. It pulses wrap one cycle after a
// counting step that crossed the modulo boundary.
//
// Ports:
//   clk, rst    clock (rising edge), synchronous active-high reset
//   cmd         command channel (ubc_sequencer_if.slave)
//   pause       while high, counting steps are held off
//   ctr_out     counter value fed back from ubc.out
//   ctr_load    to ubc.load
//   ctr_in      to ubc.in
//   ctr_enable  to ubc.enable
//   ctr_isUp    to ubc.isUp
//   busy        a command is in progress
//   done        one-cycle pulse at command completion
//   wrap        one-cycle pulse after a wrapping step
//   state_dbg   current FSM state, for observation only
// ----------------------------------------------------------------------------
module ubc_sequencer #(
    parameter int WIDTH = 4,
    parameter int STEPW = 8
) (
    input  logic             clk,
    input  logic             rst,
    ubc_sequencer_if.slave   cmd,
    input  logic             pause,
    input  logic [WIDTH-1:0] ctr_out,
    output logic             ctr_load,
    output logic [WIDTH-1:0] ctr_in,
    output logic             ctr_enable,
    output logic             ctr_isUp,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_UP   = 3'd2,
        S_DOWN = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_UP     = 2'b01;
    localparam logic [1:0] OP_DOWN   = 2'b10;
    localparam logic [1:0] OP_BOUNCE = 2'b11;

    state_t           state;
    logic [STEPW-1:0] steps_left;
    logic [STEPW-1:0] bounce_steps;
    logic             bounce;

    // Every control output is a plain decode of the state register.
    // ctr_enable also looks at pause, so that a paused cycle never steps
    // the counter.
    assign cmd.cmd_ready = (state == S_IDLE);
    assign ctr_load      = (state == S_LOAD);
    assign ctr_isUp      = (state == S_UP);
    assign ctr_enable    = ((state == S_UP) || (state == S_DOWN)) && !pause;
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign state_dbg     = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            steps_left   <= '0;
            bounce_steps <= '0;
            bounce       <= 1'b0;
            ctr_in       <= '0;
            wrap         <= 1'b0;
        end else begin
            // The step taken at this edge wraps when it leaves the top
            // value going up, or leaves zero going down.
            wrap <= ctr_enable &&
                    (ctr_isUp ? (ctr_out == {WIDTH{1'b1}}) : (ctr_out == '0));

            case (state)
                S_IDLE: begin
                    if (cmd.cmd_valid) begin
                        case (cmd.cmd_op)
                            OP_LOAD: begin
                                ctr_in <= cmd.cmd_data;
                                state  <= S_LOAD;
                            end
                            OP_UP: begin
                                steps_left <= cmd.cmd_steps;
                                state      <= (cmd.cmd_steps == '0) ? S_DONE : S_UP;
                            end
                            OP_DOWN: begin
                                steps_left <= cmd.cmd_steps;
                                state      <= (cmd.cmd_steps == '0) ? S_DONE : S_DOWN;
                            end
                            OP_BOUNCE: begin
                                steps_left   <= cmd.cmd_steps;
                                bounce_steps <= cmd.cmd_steps;
                                bounce       <= 1'b1;
                                state        <= (cmd.cmd_steps == '0) ? S_DONE : S_UP;
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end

                S_LOAD: state <= S_DONE;

                S_UP, S_DOWN: begin
                    if (!pause) begin
                        steps_left <= steps_left - STEPW'(1);
                        // The last step of this leg is the one that takes
                        // steps_left from 1 to 0.
                        if (steps_left == STEPW'(1)) begin
                            if ((state == S_UP) && bounce) begin
                                steps_left <= bounce_steps;
                                bounce     <= 1'b0;
                                state      <= S_DOWN;
                            end else begin
                                state <= S_DONE;
                            end
                        end
                    end
                end

                S_DONE: begin
                    // A zero-step BOUNCE reaches here with bounce still set.
                    bounce <= 1'b0;
                    state  <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ubc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ubc_sequencer
// Drives directed commands into ubc_sequencer. A behavioural ubc counter
// closes the ctr_* loop. For each issued command the bench pushes the
// hand-computed expected response: done latency, enable cycles, load
// cycles, wrap pulses and final counter value. A negedge monitor counts
// activity from the accept edge. When done appears, the monitor pops the
// expected response and compares it.
// ----------------------------------------------------------------------------
module tb_ubc_sequencer;

    localparam int WIDTH = 4;
    localparam int STEPW = 8;
    localparam int EW    = 28;  // {lat[7:0], en[7:0], ld[3:0], wr[3:0], val[3:0]}

    logic             clk;
    logic             rst;
    logic             pause;
    logic [WIDTH-1:0] ctr_out;
    logic             ctr_load;
    logic [WIDTH-1:0] ctr_in;
    logic             ctr_enable;
    logic             ctr_isUp;
    logic             busy;
    logic             done;
    logic             wrap;
    logic [2:0]       state_dbg;

    ubc_sequencer_if #(.WIDTH(WIDTH), .STEPW(STEPW)) cmd_if ();

    ubc_sequencer #(.WIDTH(WIDTH), .STEPW(STEPW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd_if.slave),
        .pause      (pause),
        .ctr_out    (ctr_out),
        .ctr_load   (ctr_load),
        .ctr_in     (ctr_in),
        .ctr_enable (ctr_enable),
        .ctr_isUp   (ctr_isUp),
        .busy       (busy),
        .done       (done),
        .wrap       (wrap),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ubc. The sequencer's rst does not touch it.
    logic [WIDTH-1:0] ctr_q = '0;
    always @(posedge clk) begin
        if (ctr_load)        ctr_q <= ctr_in;
        else if (ctr_enable) ctr_q <= ctr_isUp ? ctr_q + 1'b1 : ctr_q - 1'b1;
    end
    assign ctr_out = ctr_q;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [EW-1:0] pack(input int lat, input int en, input int ld,
                                           input int wr, input int val);
        pack = {lat[7:0], en[7:0], ld[3:0], wr[3:0], val[3:0]};
    endfunction

    // ---------------- monitor ----------------
    bit            active = 0;
    int            cyc, en_c, ld_c, wr_c;
    logic [EW-1:0] e;

    always @(negedge clk) begin
        if (rst) begin
            active = 0;  // command abandoned, nothing expected from it
        end else begin
            if (active) begin
                cyc++;
                if (ctr_enable) en_c++;
                if (ctr_load)   ld_c++;
                if (wrap)       wr_c++;
                if (done) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        $display("FAIL done_no_expect: got done at cycle %0d expected none", cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_latency", cyc,  32'(e[27:20]));
                        check("enable_cycles", en_c, 32'(e[19:12]));
                        check("load_cycles",  ld_c, 32'(e[11:8]));
                        check("wrap_pulses",  wr_c, 32'(e[7:4]));
                        check("ctr_out",      32'(ctr_out), 32'(e[3:0]));
                    end
                    active = 0;
                end
            end else if (done) begin
                n_total++;
                $display("FAIL stray_done: got done=1 expected 0 with no command");
            end
            if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
                active = 1;
                cyc = 0; en_c = 0; ld_c = 0; wr_c = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Returns #1 after the accept edge, i.e. early in cycle 1.
    task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] data,
                        input logic [STEPW-1:0] steps);
        bit ok = 0;
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_data  = data;
        cmd_if.cmd_steps = steps;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (cmd_if.cmd_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL accept_timeout: got cmd_ready=0 expected 1");
        end
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL done_timeout: got no done expected done within 60 cycles");
        end
    endtask

    task automatic step_cycle();
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 32'(cmd_if.cmd_ready), 1);
        check({tag, "_busy"},      32'(busy),       0);
        check({tag, "_done"},      32'(done),       0);
        check({tag, "_wrap"},      32'(wrap),       0);
        check({tag, "_ctr_load"},  32'(ctr_load),   0);
        check({tag, "_ctr_enable"},32'(ctr_enable), 0);
        check({tag, "_ctr_isUp"},  32'(ctr_isUp),   0);
        check({tag, "_ctr_in"},    32'(ctr_in),     0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        pause = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'b00;
        cmd_if.cmd_data  = '0;
        cmd_if.cmd_steps = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // LOAD 9: load in cycle 1, done in cycle 2.
        exp_q.push_back(pack(2, 0, 1, 0, 9));
        send(2'b00, 4'd9, 8'd0);
        wait_done();

        // UP 3 from 9 -> 12, done at 4, no wrap.
        exp_q.push_back(pack(4, 3, 0, 0, 12));
        send(2'b01, 4'd0, 8'd3);
        wait_done();

        // LOAD 1, then DOWN 2 -> 0 -> 15, one wrap, done at 3.
        exp_q.push_back(pack(2, 0, 1, 0, 1));
        send(2'b00, 4'd1, 8'd0);
        wait_done();
        exp_q.push_back(pack(3, 2, 0, 1, 15));
        send(2'b10, 4'd0, 8'd2);
        wait_done();

        // LOAD 14, BOUNCE 5 -> up to 3 and back to 14, two wraps, done at 11.
        exp_q.push_back(pack(2, 0, 1, 0, 14));
        send(2'b00, 4'd14, 8'd0);
        wait_done();
        exp_q.push_back(pack(11, 10, 0, 2, 14));
        send(2'b11, 4'd0, 8'd5);
        wait_done();

        // LOAD 0, UP 4 with pause in cycles 2-3, stray cmd_valid while busy.
        exp_q.push_back(pack(2, 0, 1, 0, 0));
        send(2'b00, 4'd0, 8'd0);
        wait_done();
        exp_q.push_back(pack(7, 4, 0, 0, 4));
        send(2'b01, 4'd0, 8'd4);
        cmd_if.cmd_valid = 1'b1;      // cycle 1: LOAD 5 must be ignored
        cmd_if.cmd_op    = 2'b00;
        cmd_if.cmd_data  = 4'd5;
        step_cycle();                 // cycle 2
        pause = 1'b1;
        step_cycle();                 // cycle 3
        step_cycle();                 // cycle 4
        pause = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        wait_done();

        // UP 0: done in cycle 1, no enable, value unchanged.
        exp_q.push_back(pack(1, 0, 0, 0, 4));
        send(2'b01, 4'd0, 8'd0);
        wait_done();

        // LOAD 6, then DOWN 10 with rst raised at cycle 4.
        // Enables in cycles 1..4 take 6 down to 2, then the counter holds.
        exp_q.push_back(pack(2, 0, 1, 0, 6));
        send(2'b00, 4'd6, 8'd0);
        wait_done();
        send(2'b10, 4'd0, 8'd10);     // now in cycle 1, no expectation pushed
        step_cycle();                 // cycle 2
        step_cycle();                 // cycle 3
        step_cycle();                 // cycle 4
        rst = 1'b1;
        step_cycle();                 // cycle 5: back in reset state
        check_reset_outputs("midrst");
        check("midrst_ctr_out", 32'(ctr_out), 2);
        rst = 1'b0;
        repeat (3) step_cycle();
        check("midrst_frozen_ctr_out", 32'(ctr_out), 2);
        check("midrst_idle_busy", 32'(busy), 0);

        // Recovery: LOAD 3 after the abandoned command.
        exp_q.push_back(pack(2, 0, 1, 0, 3));
        send(2'b00, 4'd3, 8'd0);
        wait_done();
        repeat (2) step_cycle();

        check("expect_queue_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish before 100000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ubc_sequencer.md
# ubc_sequencer

Command-driven controller for the team's loadable up/down binary counter (`ubc`, WIDTH-bit). It accepts one command at a time over a valid/ready handshake and drives the counter's `load`/`in`/`enable`/`isUp` controls to execute it: load a value, count up or down N steps, or bounce (up N, then down N). It reports completion and wrap-around, and sits between a host/control FSM and one `ubc` instance in the datapath.

## Interface
- `WIDTH`, 4, counter width; must match the controlled `ubc`.
- `STEPW`, 8, width of the step-count argument; maximum steps per command is 2^STEPW−1.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_op`  in  2  00 LOAD, 01 UP, 10 DOWN, 11 BOUNCE.
- `cmd_data`  in  WIDTH  load value (LOAD only).
- `cmd_steps`  in  STEPW  step count (UP/DOWN/BOUNCE).
- `pause`  in  1  while high, counting steps are suspended.
- `ctr_out`  in  WIDTH  current counter value, fed back from `ubc.out`.
- `ctr_load`  out  1  to `ubc.load`.
- `ctr_in`  out  WIDTH  to `ubc.in`.
- `ctr_enable`  out  1  to `ubc.enable`.
- `ctr_isUp`  out  1  to `ubc.isUp`.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle pulse at command completion.
- `wrap`  out  1  one-cycle pulse after a counting step that wrapped.

## Operation
- FSM states: IDLE, LOAD, UP, DOWN, DONE. Registers: `state`, `steps_left` (STEPW), `bounce` flag, `bounce_steps` (STEPW), `ctr_in`, `wrap`.
- `cmd_ready` = (state == IDLE). A command is accepted on a rising edge with `cmd_valid && cmd_ready`; `cmd_valid` while not ready is ignored (no queueing).
- On accept:
  - LOAD → LOAD, `ctr_in` ← `cmd_data`.
  - UP → UP, `steps_left` ← `cmd_steps`.
  - DOWN → DOWN, `steps_left` ← `cmd_steps`.
  - BOUNCE → UP, `steps_left` and `bounce_steps` ← `cmd_steps`, `bounce` ← 1.
  - For UP, DOWN or BOUNCE with `cmd_steps` == 0: go directly to DONE; no enable cycles.
- LOAD → DONE after one cycle.
- Output decode:
  - `ctr_load` = (state == LOAD).
  - `ctr_enable` = (state ∈ {UP, DOWN}) && !pause. This is combinational from the state register and `pause`.
  - `ctr_isUp` = (state == UP).
  - `busy` = (state != IDLE).
  - `done` = (state == DONE).
- UP/DOWN, on each edge with `ctr_enable`:
  - `steps_left` decrements.
  - When it reaches 0: from UP with `bounce` set, go to DOWN, load `steps_left` ← `bounce_steps` and clear `bounce`; otherwise go to DONE.
- DONE → IDLE after one cycle.
- Wrap: `wrap` is registered, set for one cycle after an edge where `ctr_enable && ctr_isUp && ctr_out == 2^WIDTH−1`, or `ctr_enable && !ctr_isUp && ctr_out == 0`. Otherwise it is 0.
- The counter wraps modulo 2^WIDTH. The sequencer never saturates and never alters `ctr_out` other than through enable and load.

## Timing
- Reset values: state IDLE; `cmd_ready`=1, `busy`=0, `done`=0, `wrap`=0, `ctr_load`=0, `ctr_enable`=0, `ctr_isUp`=0; `ctr_in`=0, `steps_left`=0, `bounce`=0.
- Cycle numbering: the accept edge ends cycle 0.
  - LOAD: `ctr_load`=1 in cycle 1; `done` in cycle 2; `cmd_ready` in cycle 3.
  - UP/DOWN N, no pause: `ctr_enable`=1 in cycles 1..N; `done` in cycle N+1; ready in N+2. Each pause cycle adds one cycle.
  - BOUNCE N: up-enable in cycles 1..N, down-enable in cycles N+1..2N, `done` in cycle 2N+1.
  - Steps 0: `done` in cycle 1.
- `pause` asserted during LOAD or DONE has no effect. `pause` in IDLE does not block acceptance.
- `rst` mid-command: at the next edge return to the reset values. The command is abandoned and no `done` is issued. The counter keeps its current value.
- Minimum command-to-command spacing: LOAD 3 cycles; UP/DOWN N+2 cycles.

## Test plan
- After `rst`, LOAD 9 → `ctr_load`=1 with `ctr_in`=9 for exactly 1 cycle; `done` the next cycle; `ctr_out`=9.
- From 9, UP 3 → `ctr_enable`=1 and `ctr_isUp`=1 for 3 cycles; `ctr_out`=12; `done` at cycle 4; no `wrap`.
- From 1, DOWN 2 → `ctr_out` goes 0, then 15; `wrap` pulses once, the cycle after the 0→15 step; `done` at cycle 3.
- From 14, BOUNCE 5 → 5 up-cycles (14→3, one `wrap`), then 5 down-cycles (3→14, one `wrap`); final value 14; `done` at cycle 11.
- From 0, UP 4 with `pause` high for 2 cycles mid-command → exactly 4 enable cycles; final value 4; `done` at cycle 7. A second `cmd_valid` while busy is ignored.
- UP 0 → `done` at cycle 1 with no enable. Also: `rst` asserted during DOWN 10 at cycle 4 → next cycle IDLE, all outputs at reset values, no `done`, `ctr_out` frozen.
